// File: rtl/pc_pkg.sv
// Shared definitions for the program counter with return-address stack:
// function-select encodings and a constant-evaluable ceiling log2.
package pc_pkg;

   localparam logic [2:0] PS_HOLD  = 3'b000;
   localparam logic [2:0] PS_INC   = 3'b001;
   localparam logic [2:0] PS_JMP   = 3'b010;
   localparam logic [2:0] PS_BR    = 3'b011;
   localparam logic [2:0] PS_CALL  = 3'b100;
   localparam logic [2:0] PS_CALLR = 3'b101;
   localparam logic [2:0] PS_RET   = 3'b110;
   localparam logic [2:0] PS_RSVD  = 3'b111;

   // Ceiling log2; clog2(1) = 0. Usable in parameter expressions.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((32'd1 << i) < value) result = unsigned'(i + 1);
      end
      return result;
   endfunction

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack. When full, a push overwrites the oldest
// entry and sets the sticky ovf flag; a pop while empty only sets sticky unf.
// top reads 0 whenever the stack is empty.
module return_address_stack
   import pc_pkg::*;
#(
   parameter int unsigned WIDTH     = 64,
   parameter int unsigned RAS_DEPTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             stall,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] top,
   output logic             empty,
   output logic             full,
   output logic             ovf,
   output logic             unf
);

   localparam int unsigned PTR_W = clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = clog2(RAS_DEPTH + 1);

   logic [WIDTH-1:0] mem [RAS_DEPTH];
   logic [PTR_W-1:0] top_ptr;
   logic [PTR_W-1:0] ptr_inc;
   logic [PTR_W-1:0] ptr_dec;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(RAS_DEPTH));
   assign top     = empty ? '0 : mem[top_ptr];
   assign do_push = push & ~stall;
   assign do_pop  = pop & ~push & ~stall;

   // Pointer neighbours with explicit wrap so non-power-of-two depths work.
   always_comb begin
      ptr_inc = (top_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : top_ptr + 1'b1;
      ptr_dec = (top_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : top_ptr - 1'b1;
   end

   // Entry storage; contents are don't-care until pushed, so no reset.
   always_ff @(posedge clock) begin
      if (do_push) mem[ptr_inc] <= data;
   end

   // Top pointer, occupancy and sticky error flags.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         top_ptr <= PTR_W'(RAS_DEPTH - 1);
         count   <= '0;
         ovf     <= 1'b0;
         unf     <= 1'b0;
      end else if (do_push) begin
         top_ptr <= ptr_inc;
         if (full) ovf <= 1'b1;
         else      count <= count + 1'b1;
      end else if (do_pop) begin
         if (empty) begin
            unf <= 1'b1;
         end else begin
            top_ptr <= ptr_dec;
            count   <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/program_counter_ras.sv
// Program counter with call/return via an internal return-address stack.
// Optional build macro PC_MISALIGN_TRAP_EN: misaligned next-pc values are
// replaced by TRAP_VECTOR and flagged on the sticky misalign output.
module program_counter_ras
   import pc_pkg::*;
#(
   parameter int unsigned     WIDTH        = 64,
   parameter int unsigned     STEP         = 4,
   parameter int unsigned     RAS_DEPTH    = 8,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0
`ifdef PC_MISALIGN_TRAP_EN
   ,
   parameter logic [WIDTH-1:0] TRAP_VECTOR  = ~(WIDTH'(STEP - 1))
`endif
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] in,
   input  logic [2:0]       ps,
   input  logic             stall,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc4,
   output logic [WIDTH-1:0] ras_top,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_ovf,
   output logic             ras_unf
`ifdef PC_MISALIGN_TRAP_EN
   ,
   output logic             misalign
`endif
);

   localparam int unsigned SHIFT = clog2(STEP);

   logic [WIDTH-1:0] offset;
   logic [WIDTH-1:0] branch_target;
   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] next_pc;
   logic             push;
   logic             pop;
   logic             misaligned;

   assign pc4           = pc + WIDTH'(STEP);
   assign offset        = in << SHIFT;
   assign branch_target = pc4 + offset;
   assign push          = (ps == PS_CALL) || (ps == PS_CALLR);
   assign pop           = (ps == PS_RET);

   return_address_stack #(
      .WIDTH     (WIDTH),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .stall (stall),
      .data  (pc4),
      .top   (ras_top),
      .empty (ras_empty),
      .full  (ras_full),
      .ovf   (ras_ovf),
      .unf   (ras_unf)
   );

   // Next-pc select; RET on an empty stack falls through like INC.
   always_comb begin
      target = pc;
      case (ps)
         PS_HOLD:  target = pc;
         PS_INC:   target = pc4;
         PS_JMP:   target = in;
         PS_BR:    target = branch_target;
         PS_CALL:  target = in;
         PS_CALLR: target = branch_target;
         PS_RET:   target = ras_empty ? pc4 : ras_top;
         default:  target = pc;
      endcase
`ifdef PC_MISALIGN_TRAP_EN
      misaligned = |(target & WIDTH'(STEP - 1));
      next_pc    = misaligned ? TRAP_VECTOR : target;
`else
      misaligned = 1'b0;
      next_pc    = target;
`endif
   end

   // PC register; stall freezes it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)       pc <= RESET_VECTOR;
      else if (!stall) pc <= next_pc;
   end

`ifdef PC_MISALIGN_TRAP_EN
   // Sticky misalignment flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                    misalign <= 1'b0;
      else if (!stall && misaligned) misalign <= 1'b1;
   end
`else
   logic unused_misaligned;
   assign unused_misaligned = misaligned;
`endif

endmodule
